// File: rtl/display_scan_controller_pkg.sv
// Shared constants for the display scan path: lock state codes, digit geometry, anode polarity.
// Latency: n/a (constants and a pure helper); backpressure: n/a.
package display_scan_controller_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;
    localparam int STATE_W    = 3;

    localparam logic [STATE_W-1:0] ST_EDIT_NEW     = 3'd0;
    localparam logic [STATE_W-1:0] ST_EDIT_ENTRY   = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOCKED       = 3'd2;
    localparam logic [STATE_W-1:0] ST_EDIT_CONFIRM = 3'd3;
    localparam logic [STATE_W-1:0] ST_UNLOCKED     = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERROR        = 3'd5;
    localparam logic [STATE_W-1:0] ST_ALARM        = 3'd6;
    localparam logic [STATE_W-1:0] ST_RESERVED     = 3'd7;

    // Bit n set: state n blinks the digit under the position pointer.
    localparam logic [NUM_DIGITS-1:0] DEFAULT_BLINK_STATE_MASK = 8'b0000_1011;

    localparam logic                  ANODE_ON      = 1'b0;
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = {NUM_DIGITS{~ANODE_ON}};

    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [DIGIT_W-1:0] digit);
        return ANODE_ALL_OFF ^ (NUM_DIGITS'(1) << digit);
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between the lock FSM / display pins and the scan controller.
// Latency: n/a (wiring only); backpressure: none, all signals are level or single-cycle pulses.
interface display_scan_controller_if;
    import display_scan_controller_pkg::*;

    logic                  display_en;
    logic [STATE_W-1:0]    state;
    logic [DIGIT_W-1:0]    position_pointer;
    logic [DIGIT_W-1:0]    refreshcounter;
    logic [NUM_DIGITS-1:0] anode;
    logic                  slot_tick;
    logic                  frame_tick;
    logic                  blink_phase;

    modport master (
        output display_en, state, position_pointer,
        input  refreshcounter, anode, slot_tick, frame_tick, blink_phase
    );

    modport slave (
        input  display_en, state, position_pointer,
        output refreshcounter, anode, slot_tick, frame_tick, blink_phase
    );

endinterface

// File: rtl/display_scan_controller_tick_divider.sv
// Free-running modulo-DIV counter with a registered tick high while count == DIV-1.
// Latency: tick aligned with the count it flags; backpressure: none, never stalls.
module tick_divider #(
    parameter int  DIV = 50000,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= (count_d == LAST);
        end
    end

    assign count = count_q;
    assign tick  = tick_q;

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan sequencer: prescaled slot counter, dead-time gated one-hot-low anode, edit-digit blink.
// Latency: all outputs registered, anode always aligned with refreshcounter; backpressure: none.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int                    REFRESH_DIV      = 50000,
    parameter int                    DEAD_CYCLES      = 500,
    parameter int                    BLINK_FRAMES     = 64,
    parameter logic [NUM_DIGITS-1:0] BLINK_STATE_MASK = DEFAULT_BLINK_STATE_MASK
) (
    input  logic                     clk,
    input  logic                     reset,
    display_scan_controller_if.slave bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]      PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]      DEAD_LIMIT = PW'(DEAD_CYCLES);
    localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    logic [PW-1:0]         prescaler, prescaler_d;
    logic                  slot_tick;
    logic [DIGIT_W-1:0]    rc_q, rc_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  blink_active;
    logic                  blanked;

    tick_divider #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (slot_tick),
        .count (prescaler)
    );

    always_comb begin
        prescaler_d   = slot_tick ? '0 : prescaler + PW'(1);
        rc_d          = slot_tick ? rc_q + DIGIT_W'(1) : rc_q;
        frame_tick_d  = (prescaler_d == PRE_LAST) && (rc_d == LAST_DIGIT);
        blink_active  = BLINK_STATE_MASK[bus.state];
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        // Leaving an edit state wins over a coincident frame end, so re-entry starts visible.
        if (!blink_active) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        // Gate with next-cycle slot and phase so the strobe never lags the counter.
        blanked = !bus.display_en
               || (prescaler_d < DEAD_LIMIT)
               || (blink_active && !blink_phase_d && (bus.position_pointer == rc_d));
        anode_d = blanked ? ANODE_ALL_OFF : anode_for(rc_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rc_q          <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            anode_q       <= ANODE_ALL_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            rc_q          <= rc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign bus.refreshcounter = rc_q;
    assign bus.anode          = anode_q;
    assign bus.slot_tick      = slot_tick;
    assign bus.frame_tick     = frame_tick_q;
    assign bus.blink_phase    = blink_phase_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized scoreboard bench: time-based reference model pushes expectations, a monitor pops and compares.
module tb_display_scan_controller;
    import display_scan_controller_pkg::*;

    localparam int         DIV   = 4;
    localparam int         DEAD  = 1;
    localparam int         BF    = 2;
    localparam int         FRAME = DIV * 8;
    localparam logic [7:0] MASK  = 8'b0000_1011;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_controller_if bus ();

    display_scan_controller #(
        .REFRESH_DIV      (DIV),
        .DEAD_CYCLES      (DEAD),
        .BLINK_FRAMES     (BF),
        .BLINK_STATE_MASK (MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] rc;
        logic [7:0] an;
        logic       st;
        logic       ft;
        logic       bp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_slot   = 0;
    int   m_pres   = 0;
    logic m_phase  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    // Reference: t = clocks since reset, n = frame ends seen while in an edit state.
    initial begin : model
        int   t;
        int   n;
        bit   fe;
        bit   act;
        exp_t e;
        t   = 0;
        n   = 0;
        act = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                t   = 0;
                n   = 0;
                act = 1'b0;
            end else begin
                fe  = (t % FRAME) == FRAME - 1;
                t++;
                act = MASK[bus.state];
                if (!act) n = 0;
                else if (fe) n++;
            end
            m_pres  = t % DIV;
            m_slot  = (t / DIV) % 8;
            m_phase = ((n / BF) % 2) == 0;
            e.rc = 3'(m_slot);
            e.st = (m_pres == DIV - 1);
            e.ft = e.st && (m_slot == 7);
            e.bp = m_phase;
            if (reset || !bus.display_en || m_pres < DEAD
                || (act && !m_phase && int'(bus.position_pointer) == m_slot))
                e.an = 8'hFF;
            else
                e.an = ~(8'(1) << m_slot);
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("refreshcounter", 32'(bus.refreshcounter), 32'(e.rc));
                check("anode",          32'(bus.anode),          32'(e.an));
                check("slot_tick",      32'(bus.slot_tick),      32'(e.st));
                check("frame_tick",     32'(bus.frame_tick),     32'(e.ft));
                check("blink_phase",    32'(bus.blink_phase),    32'(e.bp));
                check("anode_one_low",  32'($countones(~bus.anode) <= 1), 32'd1);
            end
        end
    end

    task automatic wait_slot(input int slot, input int pres);
        int guard;
        guard = 0;
        while (!(m_slot == slot && m_pres == pres) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("wait_slot_bound", 32'(guard < 400), 32'd1);
    endtask

    task automatic wait_blank();
        int guard;
        guard = 0;
        while (m_phase != 1'b0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("wait_blank_bound", 32'(guard < 400), 32'd1);
    endtask

    initial begin : stimulus
        bus.display_en       = 1'b1;
        bus.state            = ST_LOCKED;
        bus.position_pointer = 3'd0;
        reset                = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);

        bus.state            = ST_EDIT_ENTRY;
        bus.position_pointer = 3'd2;
        repeat (160) @(negedge clk);

        wait_blank();
        bus.state = ST_LOCKED;
        repeat (40) @(negedge clk);
        bus.state = ST_EDIT_NEW;
        repeat (100) @(negedge clk);

        wait_slot(5, 1);
        bus.display_en = 1'b0;
        repeat (10) @(negedge clk);
        bus.display_en = 1'b1;
        repeat (20) @(negedge clk);

        wait_slot(6, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        bus.state            = ST_EDIT_ENTRY;
        bus.position_pointer = 3'd2;
        wait_blank();
        bus.position_pointer = 3'd5;
        repeat (70) @(negedge clk);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(127) == 0) bus.state = 3'($urandom_range(7));
            if ($urandom_range(31) == 0) bus.position_pointer = 3'($urandom_range(7));
            if ($urandom_range(63) == 0) bus.display_en = ~bus.display_en;
            reset = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
